// File: rtl/traffic_phase_controller.sv
// rtl/traffic_phase_controller.sv - two-approach traffic phase controller, pedestrian path under TRAFFIC_PED_EN
module traffic_phase_controller #(
    parameter int TICK_DIV    = 100000000,
    parameter int GREEN_TIME  = 10,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 1,
    parameter int MIN_GREEN   = 3,
    parameter int WALK_TIME   = 5,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             manual_override,
    input  logic [1:0]       manual_phase,
    input  logic             ped_req,
    output logic             ns_r,
    output logic             ns_y,
    output logic             ns_g,
    output logic             ew_r,
    output logic             ew_y,
    output logic             ew_g,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] time_remaining,
    output logic             tick,
    output logic             ped_walk
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5
    } state_t;

    localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [CNT_W-1:0] T_GREEN  = CNT_W'(GREEN_TIME);
    localparam logic [CNT_W-1:0] T_YELLOW = CNT_W'(YELLOW_TIME);
    localparam logic [CNT_W-1:0] T_ALLRED = CNT_W'(ALLRED_TIME);
    localparam logic [CNT_W-1:0] T_ONE    = CNT_W'(1);

    // Lamp vector order: {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}
    localparam logic [5:0] L_NS_GO   = 6'b001_100;
    localparam logic [5:0] L_NS_SLOW = 6'b010_100;
    localparam logic [5:0] L_ALL_RED = 6'b100_100;
    localparam logic [5:0] L_EW_GO   = 6'b100_001;
    localparam logic [5:0] L_EW_SLOW = 6'b100_010;

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_cnt_n;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] time_rem;
    logic [CNT_W-1:0] time_rem_n;
    logic [5:0]       lamps;
    logic [5:0]       lamps_n;
    logic             walk;
    logic             walk_n;
    logic             flash;
    logic             flash_n;
    logic             ovr_d;

`ifdef TRAFFIC_PED_EN
    localparam logic [CNT_W-1:0] T_MIN  = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] T_WALK = CNT_W'(WALK_TIME);

    logic ped_pending;
    logic ped_pending_n;
    logic ped_serve;
    logic ped_serve_n;
`else
    logic unused_ped;
    assign unused_ped = ped_req | (MIN_GREEN == 0) | (WALK_TIME == 0);
`endif

    function automatic state_t next_of(input state_t s);
        case (s)
            NS_GREEN:  next_of = NS_YELLOW;
            NS_YELLOW: next_of = ALLRED_A;
            ALLRED_A:  next_of = EW_GREEN;
            EW_GREEN:  next_of = EW_YELLOW;
            EW_YELLOW: next_of = ALLRED_B;
            default:   next_of = NS_GREEN;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] dur_of(input state_t s);
        case (s)
            NS_GREEN, EW_GREEN:   dur_of = T_GREEN;
            NS_YELLOW, EW_YELLOW: dur_of = T_YELLOW;
            default:              dur_of = T_ALLRED;
        endcase
    endfunction

    function automatic logic [5:0] lamps_of(input state_t s);
        case (s)
            NS_GREEN:  lamps_of = L_NS_GO;
            NS_YELLOW: lamps_of = L_NS_SLOW;
            EW_GREEN:  lamps_of = L_EW_GO;
            EW_YELLOW: lamps_of = L_EW_SLOW;
            default:   lamps_of = L_ALL_RED;
        endcase
    endfunction

    // Divider wraps at TICK_DIV-1; tick is registered so it is high while the count sits at the last value
    always_comb begin
        div_cnt_n = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_ONE;
    end

    // Divider state and tick strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            div_cnt <= div_cnt_n;
            tick    <= (div_cnt_n == DIV_LAST);
        end
    end

    // Next phase, countdown and lamps; override beats release, release beats the tick
    always_comb begin
        state_n    = state;
        time_rem_n = time_rem;
        lamps_n    = lamps;
        walk_n     = walk;
        flash_n    = flash;
`ifdef TRAFFIC_PED_EN
        ped_pending_n = ped_pending | ped_req;
        ped_serve_n   = ped_serve;
`endif
        if (manual_override) begin
            time_rem_n = '0;
            walk_n     = 1'b0;
            if (!ovr_d) begin
                flash_n = 1'b1;
            end else if (tick) begin
                flash_n = ~flash;
            end
            case (manual_phase)
                2'b00:   lamps_n = L_NS_GO;
                2'b01:   lamps_n = L_EW_GO;
                2'b10:   lamps_n = L_ALL_RED;
                default: lamps_n = {1'b0, flash_n, 1'b0, 1'b0, flash_n, 1'b0};
            endcase
        end else if (ovr_d) begin
            state_n    = ALLRED_B;
            time_rem_n = T_ALLRED;
            lamps_n    = L_ALL_RED;
            walk_n     = 1'b0;
        end else if (tick) begin
`ifdef TRAFFIC_PED_EN
            // A request seen during green earns a walk in the all-red that follows this green's yellow
            if ((state == NS_GREEN || state == EW_GREEN) && ped_pending) begin
                ped_serve_n = 1'b1;
            end
            if ((state == NS_GREEN || state == EW_GREEN) && ped_pending && (time_rem > T_MIN)) begin
                time_rem_n = T_MIN;
            end else
`endif
            if (time_rem > T_ONE) begin
                time_rem_n = time_rem - T_ONE;
            end else begin
                state_n    = next_of(state);
                time_rem_n = dur_of(state_n);
                lamps_n    = lamps_of(state_n);
                walk_n     = 1'b0;
`ifdef TRAFFIC_PED_EN
                if ((state == NS_YELLOW || state == EW_YELLOW) && ped_serve) begin
                    time_rem_n    = T_WALK;
                    walk_n        = 1'b1;
                    ped_serve_n   = 1'b0;
                    ped_pending_n = ped_req;
                end
`endif
            end
        end
    end

    // Phase register and all registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ALLRED_B;
            time_rem <= T_ALLRED;
            lamps    <= L_ALL_RED;
            walk     <= 1'b0;
            flash    <= 1'b0;
            ovr_d    <= 1'b0;
        end else begin
            state    <= state_n;
            time_rem <= time_rem_n;
            lamps    <= lamps_n;
            walk     <= walk_n;
            flash    <= flash_n;
            ovr_d    <= manual_override;
        end
    end

`ifdef TRAFFIC_PED_EN
    // Pedestrian request latch and pending-walk flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ped_pending <= 1'b0;
            ped_serve   <= 1'b0;
        end else begin
            ped_pending <= ped_pending_n;
            ped_serve   <= ped_serve_n;
        end
    end
`endif

    assign {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g} = lamps;
    assign phase          = state;
    assign time_remaining = time_rem;
    assign ped_walk       = walk;

endmodule

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

Two-approach (north-south / east-west) intersection controller: the parametrised successor to the single-approach red/yellow/green timer. It contains an internal tick divider, a six-phase timed sequence with all-red clearance, a manual override with a flashing-yellow mode, and an optional pedestrian-request path. Its `time_remaining` output feeds the existing seven-segment time display path; its lamp outputs drive the board LEDs directly.

## Interface
Parameters:
- `TICK_DIV`, default 100000000: clk cycles per timing tick (1 Hz at 100 MHz).
- `GREEN_TIME`, default 10: green duration, in ticks.
- `YELLOW_TIME`, default 3: yellow duration, in ticks.
- `ALLRED_TIME`, default 1: all-red clearance, in ticks.
- `MIN_GREEN`, default 3: green remaining after a pedestrian truncation, in ticks.
- `WALK_TIME`, default 5: all-red duration while walk is shown, in ticks.
- `CNT_W`, default 8: width of `time_remaining`. All durations must be ≥1 and <2^CNT_W.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `manual_override` in 1: level; high forces the manual phase.
- `manual_phase` in 2: 00 NS green, 01 EW green, 10 all red, 11 flashing yellow.
- `ped_req` in 1: pedestrian request; a one-cycle pulse or a level.
- `ns_r`, `ns_y`, `ns_g` out 1 each: NS lamps, active-high.
- `ew_r`, `ew_y`, `ew_g` out 1 each: EW lamps, active-high.
- `phase` out 3: current state encoding.
- `time_remaining` out CNT_W: ticks left in the current phase.
- `tick` out 1: one-cycle strobe from the divider.
- `ped_walk` out 1: walk indication.

## Operation
- **Divider**
  - Counter runs 0..TICK_DIV-1 continuously, including during override.
  - `tick`=1 for exactly the cycle in which the count equals TICK_DIV-1.
- **States, encoded in `phase`**
  - NS_GREEN=0 → NS_YELLOW=1 → ALLRED_A=2 → EW_GREEN=3 → EW_YELLOW=4 → ALLRED_B=5 → NS_GREEN. Codes 6 and 7 are never produced.
  - On entering a state, `time_remaining` loads that state's duration.
  - On each tick: if `time_remaining`>1 it decrements; if it equals 1, the state advances and the next duration loads. Each phase therefore lasts exactly its duration in ticks.
- **Lamps**
  - Exactly one lamp per approach is lit in automatic mode.
  - The approach not in green or yellow shows red. ALLRED states show red on both approaches.
- **Manual override**, evaluated every clk and taking priority over the tick logic:
  - `phase` holds its last automatic value; `time_remaining`=0.
  - Lamps follow `manual_phase`:
    - 00: NS green, EW red.
    - 01: NS red, EW green.
    - 10: all red.
    - 11: both yellow, toggling on every tick and starting lit on the first override cycle.
  - On the clk after `manual_override` falls: enter ALLRED_B with ALLRED_TIME, then resume the normal sequence.
- **Pedestrian path** (only when compiled in)
  - `ped_req` sets `ped_pending` in any cycle.
  - On a tick in NS_GREEN or EW_GREEN with `ped_pending`=1 and `time_remaining`>MIN_GREEN, `time_remaining` loads MIN_GREEN instead of decrementing.
  - The next ALLRED state lasts WALK_TIME and holds `ped_walk`=1 throughout.
  - `ped_pending` clears on entry to that ALLRED state. A `ped_req` during the walk re-arms it for the next green.
  - A request arriving in yellow or all-red is held until the next green.
- **Reset**, asserted at any time:
  - State ALLRED_B, `time_remaining`=ALLRED_TIME.
  - `ns_r`=`ew_r`=1; all other lamps 0.
  - `tick`=0, `ped_walk`=0, `ped_pending`=0, divider count 0.

## Timing
- All outputs are registered.
- `phase`, lamps, `time_remaining` and `ped_walk` change on the clk edge that samples `tick`=1. They are visible in the cycle after the strobe.
- First tick comes TICK_DIV cycles after `reset_n` deasserts. The first transition, ALLRED_B→NS_GREEN, occurs ALLRED_TIME ticks after reset.
- Override takes effect one clk after assertion, independent of tick.
- If `ped_req` coincides with a tick in green, the request is latched that cycle and acts on the following tick.
- If `ped_req` coincides with the GREEN→YELLOW transition tick, the request is served in the opposite approach's green.
- Override asserted on a tick cycle wins: no state advance.

## Configuration
- Macro: `TRAFFIC_PED_EN`.
- Defined: pedestrian path as described above.
- Undefined: `ped_req` ignored, `ped_walk` tied 0, no truncation, every all-red lasts ALLRED_TIME.

## Test plan
Bench settings: TICK_DIV=4, GREEN=5, YELLOW=2, ALLRED=1, MIN_GREEN=2, WALK=3.
- Reset release, free-run → `phase` sequence 5,0,1,2,3,4,5 with dwell of 1,5,2,1,5,2,1 ticks; `tick` every 4 clks; lamps match each phase.
- `reset_n` low mid EW_GREEN → immediately `phase`=5, `ns_r`=`ew_r`=1, `time_remaining`=1, divider restarts.
- `ped_req` pulse at NS_GREEN `time_remaining`=5 → next tick `time_remaining`=2; then NS_YELLOW for 2 ticks, then ALLRED_A for 3 ticks with `ped_walk`=1, then EW_GREEN=5.
- `ped_req` during NS_YELLOW → no change in yellow; EW_GREEN truncated to 2 on its first tick.
- `manual_override`=1 with `manual_phase`=11 for 4 ticks → `ns_y`=`ew_y` toggling 1,0,1,0 and `time_remaining`=0; on release `phase`=5 for 1 tick, then 0.
- Build without `TRAFFIC_PED_EN`, pulse `ped_req` → timing identical to the free-run case; `ped_walk` stays 0.
